// File: rtl/layer_argmax.sv
// layer_argmax: sequential signed argmax over a snapshot of a layer's zed bus.
// Ports: clk, reset (sync, active-low), start -> busy, done, valid, class_idx, max_value.
module layer_argmax #(
    parameter int number_neuron = 10,
    parameter int resolution = 8,
    localparam int IW = (number_neuron > 1) ? $clog2(number_neuron) : 1,
    localparam int CW = $clog2(number_neuron + 1),
    localparam int ZW = resolution * number_neuron
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ZW-1:0]         zed,
    output logic                  busy,
    output logic                  done,
    output logic                  valid,
    output logic [IW-1:0]         class_idx,
    output logic [resolution-1:0] max_value
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                  state, state_n;
    logic [ZW-1:0]           snap, snap_n;
    logic [resolution-1:0]   best_val, best_val_n;
    logic [IW-1:0]           best_idx, best_idx_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic                    busy_n, done_n, valid_n;
    logic [IW-1:0]           class_n;
    logic [resolution-1:0]   max_n;
    logic [resolution-1:0]   cur;

    // Element under test; cnt == number_neuron means the scan is finished
    // and no element is selected.
    always_comb begin
        cur = '0;
        for (int i = 0; i < number_neuron; i++) begin
            if (cnt == CW'(i)) begin
                cur = snap[i*resolution +: resolution];
            end
        end
    end

    always_comb begin
        state_n    = state;
        snap_n     = snap;
        best_val_n = best_val;
        best_idx_n = best_idx;
        cnt_n      = cnt;
        busy_n     = busy;
        done_n     = 1'b0;
        valid_n    = valid;
        class_n    = class_idx;
        max_n      = max_value;
        unique case (state)
            IDLE: begin
                if (start) begin
                    snap_n     = zed;
                    best_val_n = zed[resolution-1:0];
                    best_idx_n = '0;
                    cnt_n      = CW'(1);
                    busy_n     = 1'b1;
                    state_n    = SCAN;
                end
            end
            SCAN: begin
                if (cnt == CW'(number_neuron)) begin
                    class_n = best_idx;
                    max_n   = best_val;
                    done_n  = 1'b1;
                    valid_n = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    // strict compare keeps the lower index on ties
                    if ($signed(cur) > $signed(best_val)) begin
                        best_val_n = cur;
                        best_idx_n = IW'(cnt);
                    end
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            snap      <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
            class_idx <= '0;
            max_value <= '0;
        end else begin
            state     <= state_n;
            snap      <= snap_n;
            best_val  <= best_val_n;
            best_idx  <= best_idx_n;
            cnt       <= cnt_n;
            busy      <= busy_n;
            done      <= done_n;
            valid     <= valid_n;
            class_idx <= class_n;
            max_value <= max_n;
        end
    end

endmodule

// File: tb/tb_layer_argmax.sv
// tb_layer_argmax: random and directed stimulus for layer_argmax,
// checked every cycle against a transaction-level argmax model.
module tb_layer_argmax;

    localparam int N  = 10;
    localparam int R  = 8;
    localparam int IW = 4;
    localparam int ZW = N * R;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [ZW-1:0] zed = '0;
    logic          busy, done, valid;
    logic [IW-1:0] class_idx;
    logic [R-1:0]  max_value;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model outputs
    int m_busy = 0, m_done = 0, m_valid = 0;
    int m_idx = 0, m_val = 0;
    int m_left = 0, p_idx = 0, p_val = 0;

    layer_argmax #(.number_neuron(N), .resolution(R)) dut (
        .clk(clk), .reset(reset), .start(start), .zed(zed),
        .busy(busy), .done(done), .valid(valid),
        .class_idx(class_idx), .max_value(max_value)
    );

    always #5 clk = ~clk;

    function automatic void argmax(input logic [ZW-1:0] z,
                                   output int idx, output int val);
        int e;
        idx = 0;
        val = int'($signed(z[R-1:0]));
        for (int i = 1; i < N; i++) begin
            e = int'($signed(z[i*R +: R]));
            if (e > val) begin
                val = e;
                idx = i;
            end
        end
    endfunction

    // Transaction model: an accepted start yields its result N edges later.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            m_busy = 0; m_done = 0; m_valid = 0;
            m_idx = 0; m_val = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_idx = p_idx; m_val = p_val;
                    m_done = 1; m_valid = 1; m_busy = 0;
                end
            end else if (start) begin
                argmax(zed, p_idx, p_val);
                m_left = N;
                m_busy = 1;
            end
        end
    end

    task automatic compare();
        checks++;
        if ({busy, done, valid} !== {m_busy[0], m_done[0], m_valid[0]} ||
            class_idx !== IW'(m_idx) || max_value !== R'(m_val)) begin
            errors++;
            $display("FAIL model cyc=%0d got b%b d%b v%b idx=%0d val=%0d want b%0d d%0d v%0d idx=%0d val=%0d",
                     cyc, busy, done, valid, class_idx, $signed(max_value),
                     m_busy, m_done, m_valid, m_idx, m_val);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic setel(input int i, input int v);
        zed[i*R +: R] = R'(v);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check("done_timeout", int'(done === 1'b1), 1);
    endtask

    task automatic run_scan(output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
    endtask

    initial begin
        int lat, nd, t1, t2, i1, i2;
        // reset then idle
        repeat (2) tick();
        reset = 1'b1;
        repeat (20) tick();
        check("idle_valid", int'(valid), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_val", int'($signed(max_value)), 0);

        // single maximum
        setel(0, 3); setel(1, -5); setel(2, 17); setel(3, 0);
        setel(4, 90); setel(5, -128); setel(6, 45); setel(7, 89);
        setel(8, 1); setel(9, 2);
        run_scan(lat);
        check("lat", lat, 10);
        check("max_idx", int'(class_idx), 4);
        check("max_val", int'($signed(max_value)), 90);
        check("max_valid", int'(valid), 1);
        tick();
        check("done_pulse", int'(done), 0);
        check("hold_idx", int'(class_idx), 4);

        // ties and negatives
        for (int i = 0; i < N; i++) setel(i, -7);
        setel(6, -1); setel(8, -1);
        run_scan(lat);
        check("tie_idx", int'(class_idx), 6);
        check("tie_val", int'($signed(max_value)), -1);
        for (int i = 0; i < N; i++) setel(i, -128);
        run_scan(lat);
        check("min_idx", int'(class_idx), 0);
        check("min_val", int'($signed(max_value)), -128);

        // snapshot and ignored start
        zed = '0; setel(9, 127);
        start = 1'b1; tick(); start = 1'b0;
        repeat (2) tick();
        setel(2, 127); setel(9, 0);
        repeat (2) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(lat);
        check("snap_idx", int'(class_idx), 9);
        check("snap_val", int'($signed(max_value)), 127);
        nd = 0;
        repeat (15) begin tick(); nd += int'(done); end
        check("snap_nodone", nd, 0);

        // reset mid-scan after a 4/90 result
        zed = '0; setel(4, 90);
        run_scan(lat);
        check("pre_idx", int'(class_idx), 4);
        zed = '0; setel(1, 50);
        start = 1'b1; tick(); start = 1'b0;
        nd = 0;
        repeat (3) begin tick(); nd += int'(done); end
        reset = 1'b0; tick();
        check("rst_valid", int'(valid), 0);
        check("rst_idx", int'(class_idx), 0);
        check("rst_val", int'($signed(max_value)), 0);
        reset = 1'b1;
        repeat (12) begin tick(); nd += int'(done); end
        check("rst_nodone", nd, 0);
        run_scan(lat);
        check("rst_lat", lat, 10);
        check("post_idx", int'(class_idx), 1);
        check("post_val", int'($signed(max_value)), 50);
        tick();

        // back-to-back
        for (int i = 0; i < N; i++) setel(i, int'($urandom_range(0, 255)));
        start = 1'b1;
        wait_done(lat);
        t1 = cyc; i1 = int'(class_idx);
        tick();
        wait_done(lat);
        t2 = cyc; i2 = int'(class_idx);
        check("b2b_period", t2 - t1, 11);
        check("b2b_idx", i2, i1);
        start = 1'b0;
        repeat (15) tick();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            start = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < N; i++) setel(i, int'($urandom_range(0, 3)) - 2);
            end else begin
                zed = {$urandom, $urandom, $urandom};
            end
            tick();
        end
        reset = 1'b1; start = 1'b0;
        repeat (15) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
